// File: rtl/gb_host_bridge.sv
// gb_host_bridge: single-outstanding ghostbus master with valid/ready command and response streams.
module gb_host_bridge #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RD = 8,
    parameter int POSTED_WRITES = 0
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_write,
    output logic [DW-1:0] resp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic [15:0]   txn_count
);
    typedef enum logic [1:0] {IDLE, STROBE, RWAIT, RESP} state_t;
    state_t     r_state;
    logic       r_write;
    logic [7:0] r_cnt;
    assign cmd_ready = (r_state == IDLE);
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_state    <= IDLE;
            r_write    <= 1'b0;
            r_cnt      <= 8'd0;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_rdata <= '0;
            gb_addr    <= '0;
            gb_wdata   <= '0;
            gb_wen     <= 1'b0;
            gb_rstb    <= 1'b0;
            txn_count  <= 16'd0;
        end else begin
            gb_wen  <= 1'b0;
            gb_rstb <= 1'b0;
            case (r_state)
                IDLE: if (cmd_valid) begin
                    gb_addr  <= cmd_addr;
                    gb_wdata <= cmd_wdata;
                    r_write  <= cmd_write;
                    gb_wen   <= cmd_write;
                    gb_rstb  <= !cmd_write;
                    r_state  <= STROBE;
                end
                STROBE: begin
                    txn_count <= txn_count + 16'd1;
                    if (!r_write) begin
                        r_cnt   <= 8'(RD - 1);
                        r_state <= RWAIT;
                    end else if (POSTED_WRITES != 0) begin
                        r_state <= IDLE;
                    end else begin
                        resp_rdata <= '0;
                        resp_write <= 1'b1;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                // r_cnt reaches 0 in the cycle gb_rdata is due, RD cycles after the strobe
                RWAIT: if (r_cnt == 8'd0) begin
                    resp_rdata <= gb_rdata;
                    resp_write <= 1'b0;
                    resp_valid <= 1'b1;
                    r_state    <= RESP;
                end else begin
                    r_cnt <= r_cnt - 8'd1;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gb_host_bridge.sv
// tb_gb_host_bridge: checks a non-posted bridge (a_*) and a posted-write bridge (b_*) against a bus model and response scoreboard.
module tb_gb_host_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_cmd_valid = 1'b0, a_cmd_write = 1'b0, a_resp_ready = 1'b1;
    logic [23:0] a_cmd_addr = '0;
    logic [31:0] a_cmd_wdata = '0;
    logic        a_cmd_ready, a_resp_valid, a_resp_write, a_gb_wen, a_gb_rstb;
    logic [31:0] a_resp_rdata, a_gb_wdata, a_gb_rdata;
    logic [23:0] a_gb_addr;
    logic [15:0] a_txn;
    logic        b_cmd_valid = 1'b0, b_cmd_write = 1'b0, b_resp_ready = 1'b1;
    logic [23:0] b_cmd_addr = '0;
    logic [31:0] b_cmd_wdata = '0;
    logic        b_cmd_ready, b_resp_valid, b_resp_write, b_gb_wen, b_gb_rstb;
    logic [31:0] b_resp_rdata, b_gb_wdata;
    logic [31:0] b_gb_rdata = '0;
    logic [23:0] b_gb_addr;
    logic [15:0] b_txn;
    int total = 0, bad = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    gb_host_bridge #(.AW(24), .DW(32), .RD(8), .POSTED_WRITES(0)) u_a (
        .gb_clk(clk), .gb_rst_n(rst_n), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_write(a_cmd_write), .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_write(a_resp_write),
        .resp_rdata(a_resp_rdata), .gb_addr(a_gb_addr), .gb_wdata(a_gb_wdata),
        .gb_wen(a_gb_wen), .gb_rstb(a_gb_rstb), .gb_rdata(a_gb_rdata), .txn_count(a_txn));

    gb_host_bridge #(.AW(24), .DW(32), .RD(8), .POSTED_WRITES(1)) u_b (
        .gb_clk(clk), .gb_rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
        .resp_rdata(b_resp_rdata), .gb_addr(b_gb_addr), .gb_wdata(b_gb_wdata),
        .gb_wen(b_gb_wen), .gb_rstb(b_gb_rstb), .gb_rdata(b_gb_rdata), .txn_count(b_txn));

    function automatic logic [31:0] bus_val(input logic [23:0] ad);
        return (ad == 24'h20) ? 32'hDEAD_BEEF : {ad[15:0], ~ad[15:0]};
    endfunction

    // Bus model: read data is valid only in the cycle RD=8 cycles after the strobe cycle.
    logic [7:0]  a_cd = 8'd0;
    logic [23:0] a_ra = '0;
    always @(posedge clk) begin
        if (a_gb_rstb) begin
            a_cd <= 8'd8;
            a_ra <= a_gb_addr;
        end else if (a_cd != 8'd0) begin
            a_cd <= a_cd - 8'd1;
        end
    end
    assign a_gb_rdata = (a_cd == 8'd1) ? bus_val(a_ra) : ~bus_val(a_ra);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {logic w; logic [31:0] d;} resp_t;
    resp_t q[$];

    always @(negedge clk) begin
        if (rst_n && a_resp_valid && a_resp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got w=%0b d=%h want none", a_resp_write, a_resp_rdata);
            end else begin
                resp_t e;
                e = q.pop_front();
                chk("resp_write", {31'd0, a_resp_write}, {31'd0, e.w});
                chk("resp_rdata", a_resp_rdata, e.d);
            end
        end
    end

    logic a_pw = 1'b0, b_pw = 1'b0;
    always @(negedge clk) begin
        if (mon_on) begin
            chk("a_strobe_excl", {31'd0, a_gb_wen & a_gb_rstb}, 32'd0);
            chk("a_strobe_consec", {31'd0, (a_gb_wen | a_gb_rstb) & a_pw}, 32'd0);
            chk("b_strobe_consec", {31'd0, (b_gb_wen | b_gb_rstb) & b_pw}, 32'd0);
            chk("b_no_resp", {31'd0, b_resp_valid}, 32'd0);
        end
        a_pw <= a_gb_wen | a_gb_rstb;
        b_pw <= b_gb_wen | b_gb_rstb;
    end

    task automatic a_issue(input logic w, input logic [23:0] ad, input logic [31:0] wd,
                           input logic ew, input logic [31:0] ed);
        int n = 0;
        a_cmd_write = w;
        a_cmd_addr  = ad;
        a_cmd_wdata = wd;
        a_cmd_valid = 1'b1;
        while (!a_cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_cmd_ready) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got cmd_ready=0 want 1");
            a_cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            q.push_back('{ew, ed});
            #1;
            a_cmd_valid = 1'b0;
        end
    endtask

    task automatic a_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {logic w; logic [23:0] a; logic [31:0] d; logic ew; logic [31:0] ed;} vec_t;
    vec_t tv[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] seen;
        logic [9:0]  mask;
        logic [15:0] ecnt;
        int n, hs;
        tv[0] = '{1'b1, 24'h000100, 32'h0000_0001, 1'b1, 32'h0};
        tv[1] = '{1'b0, 24'h000020, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        tv[2] = '{1'b0, 24'hFFFFFF, 32'h1111_2222, 1'b0, 32'hFFFF_0000};
        tv[3] = '{1'b1, 24'hFFFFFF, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tv[4] = '{1'b0, 24'h000000, 32'h0000_0000, 1'b0, 32'h0000_FFFF};
        tv[5] = '{1'b1, 24'h0ABCDE, 32'h0000_0000, 1'b1, 32'h0};

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
        chk("rst_resp_write", {31'd0, a_resp_write}, 32'd0);
        chk("rst_resp_rdata", a_resp_rdata, 32'd0);
        chk("rst_gb_addr", {8'd0, a_gb_addr}, 32'd0);
        chk("rst_gb_wdata", a_gb_wdata, 32'd0);
        chk("rst_strobes", {30'd0, a_gb_wen, a_gb_rstb}, 32'd0);
        chk("rst_txn", {16'd0, a_txn}, 32'd0);
        chk("rst_b_ready", {31'd0, b_cmd_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;

        // Non-posted write timing.
        a_issue(1'b1, 24'h000010, 32'h0000_00A5, 1'b1, 32'h0);
        @(negedge clk);
        chk("w_wen_e1", {31'd0, a_gb_wen}, 32'd1);
        chk("w_rstb_e1", {31'd0, a_gb_rstb}, 32'd0);
        chk("w_addr_e1", {8'd0, a_gb_addr}, 32'h10);
        chk("w_wdata_e1", a_gb_wdata, 32'hA5);
        chk("w_rv_e1", {31'd0, a_resp_valid}, 32'd0);
        @(negedge clk);
        chk("w_wen_e2", {31'd0, a_gb_wen}, 32'd0);
        chk("w_rv_e2", {31'd0, a_resp_valid}, 32'd1);
        chk("w_rwrite_e2", {31'd0, a_resp_write}, 32'd1);
        chk("w_rdata_e2", a_resp_rdata, 32'd0);
        chk("w_txn", {16'd0, a_txn}, 32'd1);
        @(negedge clk);
        chk("w_ready_e3", {31'd0, a_cmd_ready}, 32'd1);
        chk("w_rv_e3", {31'd0, a_resp_valid}, 32'd0);
        @(posedge clk); #1;

        // Read timing with RD=8.
        a_issue(1'b0, 24'h000020, 32'h0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("r_rstb_e1", {31'd0, a_gb_rstb}, 32'd1);
        chk("r_wen_e1", {31'd0, a_gb_wen}, 32'd0);
        seen = 32'd0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | {30'd0, a_gb_rstb, a_resp_valid};
        end
        chk("r_quiet_e2_e9", seen, 32'd0);
        @(negedge clk);
        chk("r_rv_e10", {31'd0, a_resp_valid}, 32'd1);
        chk("r_rdata_e10", a_resp_rdata, 32'hDEAD_BEEF);
        a_drain();

        // Read response held off by resp_ready while a write waits on cmd_valid.
        a_resp_ready = 1'b0;
        a_issue(1'b0, 24'h000030, 32'h0, 1'b0, bus_val(24'h30));
        a_cmd_write = 1'b1;
        a_cmd_addr  = 24'h000040;
        a_cmd_wdata = 32'h1234_5678;
        a_cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_rv", {31'd0, a_resp_valid}, 32'd1);
            chk("hold_rdata", a_resp_rdata, bus_val(24'h30));
            chk("hold_cmd_ready", {31'd0, a_cmd_ready}, 32'd0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        a_resp_ready = 1'b1;
        @(negedge clk);
        chk("hold_ready_v5", {31'd0, a_cmd_ready}, 32'd0);
        @(negedge clk);
        chk("hold_ready_v6", {31'd0, a_cmd_ready}, 32'd1);
        q.push_back('{1'b1, 32'h0});
        @(negedge clk);
        chk("hold_wen_v7", {31'd0, a_gb_wen}, 32'd1);
        chk("hold_addr_v7", {8'd0, a_gb_addr}, 32'h40);
        chk("hold_wdata_v7", a_gb_wdata, 32'h1234_5678);
        a_cmd_valid = 1'b0;
        a_drain();

        // Posted writes back-to-back with cmd_valid held high.
        b_cmd_write = 1'b1;
        b_cmd_addr  = 24'h000077;
        b_cmd_wdata = 32'hCAFE_0001;
        b_cmd_valid = 1'b1;
        hs = 0;
        mask = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_cmd_ready && b_cmd_valid) hs++;
            mask[k] = b_gb_wen;
            @(posedge clk); #1;
            if (hs == 3) b_cmd_valid = 1'b0;
        end
        chk("posted_strobes", {22'd0, mask}, 32'h02A);
        chk("posted_txn", {16'd0, b_txn}, 32'd3);
        chk("posted_addr", {8'd0, b_gb_addr}, 32'h77);

        // Reset during RWAIT abandons the read.
        a_issue(1'b0, 24'h000050, 32'h0, 1'b0, bus_val(24'h50));
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", {31'd0, a_cmd_ready}, 32'd1);
        chk("mid_rst_resp", {30'd0, a_resp_valid, a_resp_write}, 32'd0);
        chk("mid_rst_rdata", a_resp_rdata, 32'd0);
        chk("mid_rst_addr", {8'd0, a_gb_addr}, 32'd0);
        chk("mid_rst_wdata", a_gb_wdata, 32'd0);
        chk("mid_rst_strobes", {30'd0, a_gb_wen, a_gb_rstb}, 32'd0);
        chk("mid_rst_txn", {a_txn, b_txn}, 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 32'd0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | {31'd0, a_resp_valid};
        end
        chk("mid_rst_no_resp", seen, 32'd0);
        @(posedge clk); #1;

        // Vector table after reset.
        ecnt = 16'd0;
        foreach (tv[i]) begin
            a_issue(tv[i].w, tv[i].a, tv[i].d, tv[i].ew, tv[i].ed);
            @(negedge clk);
            chk("tv_addr", {8'd0, a_gb_addr}, {8'd0, tv[i].a});
            chk("tv_strobe", {30'd0, a_gb_wen, a_gb_rstb}, tv[i].w ? 32'd2 : 32'd1);
            a_drain();
            ecnt = ecnt + 16'd1;
            chk("tv_txn", {16'd0, a_txn}, {16'd0, ecnt});
            chk("tv_wdata_held", a_gb_wdata, tv[i].d);
        end

        // txn_count wrap.
        force u_b.txn_count = 16'hFFFF;
        @(posedge clk); #1;
        release u_b.txn_count;
        b_cmd_valid = 1'b1;
        @(posedge clk); #1;
        b_cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("txn_wrap", {16'd0, b_txn}, 32'd0);

        mon_on = 1'b0;
        chk("final_queue", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
